mem_arbiter: RTL and testbench

- Two-client arbiter between the instruction cache and data cache and the single shared word-granular external memory port.
- Both client ports mirror the caches' memory-side interface.
- Arbitrates requests round-robin and forwards the winner to memory.
- Tracks outstanding reads in an in-order ID FIFO, so each i_mem_valid response returns only to the cache that issued the read.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/resp_id_fifo.sv | 51 +++++
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the instruction/data cache memory arbiter.
package mem_arb_pkg;

    // Client IDs; also the bit index of each client in the packed request vectors.
    localparam logic CLIENT_IC = 1'b0;
    localparam logic CLIENT_DC = 1'b1;

    localparam int DEPTH_DEF = 4;
    localparam int AW_DEF    = 32;

    // Occupancy counter width: one extra bit so that "full" (count == depth) is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/resp_id_fifo.sv
// 1-bit-wide in-order FIFO holding the client ID of each outstanding read.
module resp_id_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW    = cnt_w(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          push,
    input  logic          pop,
    input  logic          din,
    output logic          head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Storage write; entries need no reset because count guards every read.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally (DEPTH is a power of 2); simultaneous push/pop keeps count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between icache and dcache onto one word-granular memory port.
// Read responses are steered back to their issuer through an in-order ID FIFO.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_ic_mem_ren,
    input  logic          i_ic_mem_wen,
    input  logic [AW-1:0] i_ic_mem_addr,
    input  logic [AW-1:0] i_ic_mem_wdata,
    output logic          o_ic_mem_ready,
    output logic [AW-1:0] o_ic_mem_rdata,
    output logic          o_ic_mem_valid,
    input  logic          i_dc_mem_ren,
    input  logic          i_dc_mem_wen,
    input  logic [AW-1:0] i_dc_mem_addr,
    input  logic [AW-1:0] i_dc_mem_wdata,
    output logic          o_dc_mem_ready,
    output logic [AW-1:0] o_dc_mem_rdata,
    output logic          o_dc_mem_valid,
    input  logic          i_mem_ready,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_ren,
    output logic          o_mem_wen,
    output logic [AW-1:0] o_mem_wdata,
    input  logic [AW-1:0] i_mem_rdata,
    input  logic          i_mem_valid,
    output logic          o_err
);

    localparam int CW = cnt_w(DEPTH);

    // Client-indexed views (bit CLIENT_IC / CLIENT_DC).
    logic [1:0]         cl_ren, cl_wen, cl_req;
    logic [1:0][AW-1:0] cl_addr, cl_wdata;

    assign cl_ren   = {i_dc_mem_ren,   i_ic_mem_ren};
    assign cl_wen   = {i_dc_mem_wen,   i_ic_mem_wen};
    assign cl_addr  = {i_dc_mem_addr,  i_ic_mem_addr};
    assign cl_wdata = {i_dc_mem_wdata, i_ic_mem_wdata};
    assign cl_req   = cl_ren | cl_wen;

    logic          last_grant;
    logic          grant;
    logic          full;
    logic          fwd_ok;
    logic          rdy_base;
    logic          accept;
    logic          push, pop;
    logic          fifo_head, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;

    // Full is judged on the registered count only, so a same-cycle pop never
    // reopens ready (no i_mem_valid -> ready combinational path).
    assign full = (fifo_count == CW'(DEPTH));

    // Grant: a lone requester wins; on a tie the client not granted last time wins.
    always_comb begin
        grant = ~last_grant;
        if (cl_req[CLIENT_IC] && !cl_req[CLIENT_DC]) grant = CLIENT_IC;
        if (cl_req[CLIENT_DC] && !cl_req[CLIENT_IC]) grant = CLIENT_DC;
    end

    assign fwd_ok = !i_rst && !full && cl_req[grant];

    // ren+wen together is illegal and is forwarded as a plain read.
    assign o_mem_ren   = fwd_ok && cl_ren[grant];
    assign o_mem_wen   = fwd_ok && cl_wen[grant] && !cl_ren[grant];
    assign o_mem_addr  = fwd_ok ? cl_addr[grant]  : '0;
    assign o_mem_wdata = fwd_ok ? cl_wdata[grant] : '0;

    // Ready is meaningful even for an idle client, since caches gate ren on it.
    assign rdy_base       = i_mem_ready && !full && !i_rst;
    assign o_ic_mem_ready = rdy_base && (!cl_req[CLIENT_DC] || grant == CLIENT_IC);
    assign o_dc_mem_ready = rdy_base && (!cl_req[CLIENT_IC] || grant == CLIENT_DC);

    assign accept = fwd_ok && i_mem_ready;
    assign push   = accept && o_mem_ren && !fifo_full;
    assign pop    = !i_rst && i_mem_valid && !fifo_empty;

    // Response routing: same-cycle, steered by the FIFO head; data broadcast.
    assign o_ic_mem_valid = pop && (fifo_head == CLIENT_IC);
    assign o_dc_mem_valid = pop && (fifo_head == CLIENT_DC);
    assign o_ic_mem_rdata = i_mem_rdata;
    assign o_dc_mem_rdata = i_mem_rdata;

    // Round-robin pointer; reset to DC so the icache wins the first tie.
    always_ff @(posedge i_clk) begin
        if (i_rst)       last_grant <= CLIENT_DC;
        else if (accept) last_grant <= grant;
    end

    // Sticky error: illegal ren+wen on either client, or a response with nothing outstanding.
    always_ff @(posedge i_clk) begin
        if (i_rst) o_err <= 1'b0;
        else if ((|(cl_ren & cl_wen)) || (i_mem_valid && fifo_empty)) o_err <= 1'b1;
    end

    resp_id_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .push  (push),
        .pop   (pop),
        .din   (grant),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant order, response routing, full stall, errors, reset.
module tb_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_ic_mem_ren, i_ic_mem_wen;
    logic [31:0] i_ic_mem_addr, i_ic_mem_wdata;
    logic        o_ic_mem_ready, o_ic_mem_valid;
    logic [31:0] o_ic_mem_rdata;
    logic        i_dc_mem_ren, i_dc_mem_wen;
    logic [31:0] i_dc_mem_addr, i_dc_mem_wdata;
    logic        o_dc_mem_ready, o_dc_mem_valid;
    logic [31:0] o_dc_mem_rdata;
    logic        i_mem_ready;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic        o_mem_ren, o_mem_wen;
    logic [31:0] i_mem_rdata;
    logic        i_mem_valid;
    logic        o_err;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    mem_arbiter dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_ic_mem_ren(i_ic_mem_ren), .i_ic_mem_wen(i_ic_mem_wen),
        .i_ic_mem_addr(i_ic_mem_addr), .i_ic_mem_wdata(i_ic_mem_wdata),
        .o_ic_mem_ready(o_ic_mem_ready), .o_ic_mem_rdata(o_ic_mem_rdata),
        .o_ic_mem_valid(o_ic_mem_valid),
        .i_dc_mem_ren(i_dc_mem_ren), .i_dc_mem_wen(i_dc_mem_wen),
        .i_dc_mem_addr(i_dc_mem_addr), .i_dc_mem_wdata(i_dc_mem_wdata),
        .o_dc_mem_ready(o_dc_mem_ready), .o_dc_mem_rdata(o_dc_mem_rdata),
        .o_dc_mem_valid(o_dc_mem_valid),
        .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren),
        .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .i_mem_valid(i_mem_valid), .o_err(o_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clr();
        i_ic_mem_ren = 0; i_ic_mem_wen = 0; i_ic_mem_addr = 0; i_ic_mem_wdata = 0;
        i_dc_mem_ren = 0; i_dc_mem_wen = 0; i_dc_mem_addr = 0; i_dc_mem_wdata = 0;
        i_mem_valid = 0; i_mem_rdata = 0;
    endtask

    task automatic ic_rd(input logic [31:0] a);
        i_ic_mem_ren = 1; i_ic_mem_addr = a;
    endtask

    task automatic resp(input logic [31:0] d);
        i_mem_valid = 1; i_mem_rdata = d;
    endtask

    task automatic do_reset();
        clr(); i_rst = 1; tick(); tick(); i_rst = 0;
    endtask

    initial begin
        i_mem_ready = 1;
        clr();
        i_rst = 1;
        tick(); tick();
        // outputs forced low while in reset even with a live request
        ic_rd(32'h10); #1;
        chk("rst_ic_ready", o_ic_mem_ready, 0);
        chk("rst_dc_ready", o_dc_mem_ready, 0);
        chk("rst_mem_ren", o_mem_ren, 0);
        clr(); i_rst = 0; tick();
        chk("rst_err", o_err, 0);
        chk("rst_count", dut.u_fifo.count, 0);
        chk("idle_ic_ready", o_ic_mem_ready, 1);
        chk("idle_dc_ready", o_dc_mem_ready, 1);
        chk("idle_addr", o_mem_addr, 0);

        // ---- T1: icache line fill, 2-cycle response latency
        ic_rd(32'h100); #1;
        chk("t1_ren0", o_mem_ren, 1); chk("t1_addr0", o_mem_addr, 32'h100);
        tick(); ic_rd(32'h104); #1;
        chk("t1_addr1", o_mem_addr, 32'h104);
        tick(); ic_rd(32'h108); resp(32'hA0); #1;
        chk("t1_addr2", o_mem_addr, 32'h108);
        chk("t1_icv0", o_ic_mem_valid, 1); chk("t1_rd0", o_ic_mem_rdata, 32'hA0);
        chk("t1_dcv0", o_dc_mem_valid, 0);
        tick();
        chk("t1_cnt_pp", dut.u_fifo.count, 2);
        ic_rd(32'h10C); resp(32'hA1); #1;
        chk("t1_icv1", o_ic_mem_valid, 1); chk("t1_rd1", o_ic_mem_rdata, 32'hA1);
        chk("t1_dcv1", o_dc_mem_valid, 0);
        tick(); clr(); resp(32'hA2); #1;
        chk("t1_icv2", o_ic_mem_valid, 1); chk("t1_rd2", o_ic_mem_rdata, 32'hA2);
        tick(); resp(32'hA3); #1;
        chk("t1_icv3", o_ic_mem_valid, 1); chk("t1_rd3", o_ic_mem_rdata, 32'hA3);
        chk("t1_dcv3", o_dc_mem_valid, 0);
        tick(); clr();
        chk("t1_cnt_end", dut.u_fifo.count, 0);
        chk("t1_err", o_err, 0);

        // ---- T2: simultaneous reads after reset, icache wins first tie
        do_reset();
        ic_rd(32'h200); i_dc_mem_ren = 1; i_dc_mem_addr = 32'h300; #1;
        chk("t2_addr_ic", o_mem_addr, 32'h200);
        chk("t2_ic_rdy", o_ic_mem_ready, 1); chk("t2_dc_rdy", o_dc_mem_ready, 0);
        tick(); i_ic_mem_ren = 0; #1;
        chk("t2_addr_dc", o_mem_addr, 32'h300); chk("t2_dc_rdy2", o_dc_mem_ready, 1);
        tick(); clr(); resp(32'hB0); #1;
        chk("t2_icv", o_ic_mem_valid, 1); chk("t2_dcv_n", o_dc_mem_valid, 0);
        tick(); resp(32'hB1); #1;
        chk("t2_dcv", o_dc_mem_valid, 1); chk("t2_icv_n", o_ic_mem_valid, 0);
        chk("t2_dc_rd", o_dc_mem_rdata, 32'hB1);
        tick(); clr();
        // last grant was DC -> next tie goes to IC
        ic_rd(32'h210); i_dc_mem_ren = 1; i_dc_mem_addr = 32'h310; #1;
        chk("t2_tie2", o_mem_addr, 32'h210);
        tick(); clr(); resp(32'hB2); #1;
        chk("t2_icv2", o_ic_mem_valid, 1);
        tick(); clr();

        // ---- T3: dcache write while icache reads are outstanding
        ic_rd(32'h500); tick(); ic_rd(32'h504); tick();
        chk("t3_cnt2", dut.u_fifo.count, 2);
        ic_rd(32'h508); i_dc_mem_wen = 1; i_dc_mem_addr = 32'h400; i_dc_mem_wdata = 32'hDEADBEEF; #1;
        chk("t3_wen", o_mem_wen, 1); chk("t3_ren", o_mem_ren, 0);
        chk("t3_waddr", o_mem_addr, 32'h400); chk("t3_wdata", o_mem_wdata, 32'hDEADBEEF);
        chk("t3_ic_rdy", o_ic_mem_ready, 0);
        tick();
        chk("t3_cnt_w", dut.u_fifo.count, 2);
        i_dc_mem_wen = 0; #1;
        chk("t3_ic_addr", o_mem_addr, 32'h508);
        tick(); clr();
        chk("t3_cnt3", dut.u_fifo.count, 3);
        for (int k = 0; k < 3; k++) begin
            resp(32'hC0 + k); #1;
            chk("t3_icv", o_ic_mem_valid, 1); chk("t3_dcv", o_dc_mem_valid, 0);
            chk("t3_rd", o_ic_mem_rdata, 32'hC0 + k);
            tick(); clr();
        end
        chk("t3_cnt0", dut.u_fifo.count, 0);

        // ---- T4: fill to DEPTH, 5th read stalls until a response pops
        for (int k = 0; k < 4; k++) begin
            ic_rd(32'h600 + 4 * k); #1;
            chk("t4_acc", o_ic_mem_ready, 1);
            tick();
        end
        chk("t4_full", dut.u_fifo.count, 4);
        ic_rd(32'h610); #1;
        chk("t4_stall_rdy", o_ic_mem_ready, 0); chk("t4_stall_ren", o_mem_ren, 0);
        chk("t4_stall_addr", o_mem_addr, 0);
        tick();
        resp(32'hD0); #1;
        chk("t4_pop_v", o_ic_mem_valid, 1);
        chk("t4_pop_rdy", o_ic_mem_ready, 0); chk("t4_pop_ren", o_mem_ren, 0);
        tick(); i_mem_valid = 0; #1;
        chk("t4_cnt3", dut.u_fifo.count, 3);
        chk("t4_go_rdy", o_ic_mem_ready, 1); chk("t4_go_addr", o_mem_addr, 32'h610);
        tick(); clr();
        chk("t4_cnt4", dut.u_fifo.count, 4);
        for (int k = 1; k < 5; k++) begin
            resp(32'hD0 + k); #1;
            chk("t4_drain_v", o_ic_mem_valid, 1); chk("t4_drain_d", o_ic_mem_rdata, 32'hD0 + k);
            tick(); clr();
        end
        chk("t4_cnt0", dut.u_fifo.count, 0);
        chk("t4_err", o_err, 0);

        // ---- T5: response with nothing outstanding
        resp(32'hEE); #1;
        chk("t5_icv", o_ic_mem_valid, 0); chk("t5_dcv", o_dc_mem_valid, 0);
        tick(); clr();
        chk("t5_err", o_err, 1);
        tick(); tick();
        chk("t5_err_sticky", o_err, 1);

        // ---- T6: reset mid-fill with two reads outstanding
        ic_rd(32'h700); tick(); ic_rd(32'h704); tick(); clr();
        chk("t6_cnt2", dut.u_fifo.count, 2);
        i_rst = 1; ic_rd(32'h708); resp(32'hF0); #1;
        chk("t6_rst_icv", o_ic_mem_valid, 0); chk("t6_rst_dcv", o_dc_mem_valid, 0);
        chk("t6_rst_ren", o_mem_ren, 0); chk("t6_rst_rdy", o_ic_mem_ready, 0);
        tick(); clr(); i_rst = 0; #1;
        chk("t6_cnt0", dut.u_fifo.count, 0); chk("t6_err0", o_err, 0);
        ic_rd(32'h720); i_dc_mem_ren = 1; i_dc_mem_addr = 32'h820; #1;
        chk("t6_tie_ic", o_mem_addr, 32'h720);
        tick(); clr(); resp(32'hF1); #1;
        chk("t6_icv", o_ic_mem_valid, 1);
        tick(); clr();

        // ---- illegal ren+wen: forwarded as read, error flagged
        i_dc_mem_ren = 1; i_dc_mem_wen = 1; i_dc_mem_addr = 32'h900; #1;
        chk("ill_ren", o_mem_ren, 1); chk("ill_wen", o_mem_wen, 0);
        tick(); clr();
        chk("ill_err", o_err, 1);
        chk("ill_cnt", dut.u_fifo.count, 1);
        resp(32'h99); #1;
        chk("ill_dcv", o_dc_mem_valid, 1);
        tick(); clr();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
